// File: rtl/vedic_seq_mul_ctrl_if.sv
// vedic_seq_mul_ctrl_if
// Handshake bundle between a requester and the sequential vedic multiplier.
//   in_valid / in_ready / in_a / in_b     : operand request channel
//   out_valid / out_ready / out_p         : result channel
//   busy                                  : controller is in CALC or DONE
// Modports:
//   master : requester side (drives operands, accepts results)
//   slave  : controller side
interface vedic_seq_mul_ctrl_if #(
    parameter int CHUNKS = 2
);
    localparam int W = 3 * CHUNKS;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_p;
    logic             busy;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_p,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_p,
        output busy
    );
endinterface

// File: rtl/vedic_seq_mul_ctrl.sv
// vedic_seq_mul_ctrl
// Wide unsigned multiplier built from a single shared 3x3 vedic core.
// Operands are split into 3-bit chunks; one chunk pair is multiplied per
// cycle and the 6-bit partial product is shifted into a 2W-bit accumulator.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : vedic_seq_mul_ctrl_if.slave (operand/result handshakes, busy)
//
// vedic3bit
// Combinational 3x3 unsigned multiplier, Urdhva-Tiryagbhyam column form.
// Ports:
//   a, b : 3-bit operands
//   p    : 6-bit product

module vedic3bit (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] p
);
    logic [1:0] s1;
    logic [2:0] s2;
    logic [2:0] s3;
    logic [1:0] s4;

    // Each column sums its crosswise bit products plus the carry from the
    // column below; bit 0 of each column sum is a product bit.
    always_comb begin
        s1 = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
        s2 = {2'b00, a[2] & b[0]} + {2'b00, a[1] & b[1]}
           + {2'b00, a[0] & b[2]} + {2'b00, s1[1]};
        s3 = {2'b00, a[2] & b[1]} + {2'b00, a[1] & b[2]} + {1'b0, s2[2:1]};
        s4 = {1'b0, a[2] & b[2]} + s3[2:1];
        p  = {s4, s3[0], s2[0], s1[0], a[0] & b[0]};
    end
endmodule

// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for operands; out_p holds the previous result
// CALC  | one chunk pair per cycle, j inner / i outer, acc accumulates
// DONE  | out_valid high, out_p stable until the consumer accepts
module vedic_seq_mul_ctrl #(
    parameter int CHUNKS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    vedic_seq_mul_ctrl_if.slave    bus
);
    localparam int W  = 3 * CHUNKS;
    localparam int PW = 2 * W;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_nxt;
    logic [PW-1:0]   out_p_reg;
    logic [CW-1:0]   i;
    logic [CW-1:0]   j;

    logic [2:0]      a_chunk;
    logic [2:0]      b_chunk;
    logic [5:0]      pp;
    logic [CW:0]     ij_sum;
    logic [PW-1:0]   pp_ext;
    logic            accept;
    logic            last_step;
    logic            release_out;

    vedic3bit u_core (
        .a (a_chunk),
        .b (b_chunk),
        .p (pp)
    );

    // Outside CALC the core still sees chunk 0 so its inputs are never X.
    always_comb begin
        a_chunk = a_reg[2:0];
        b_chunk = b_reg[2:0];
        if (state == CALC) begin
            for (int k = 0; k < CHUNKS; k++) begin
                if (i == CW'(k)) a_chunk = a_reg[3*k +: 3];
                if (j == CW'(k)) b_chunk = b_reg[3*k +: 3];
            end
        end
    end

    // Weight of the partial product is 2^(3*(i+j)); i+j spans 0..2*CHUNKS-2,
    // so the shift is picked from a small set of constant shifts.
    always_comb begin
        ij_sum = {1'b0, i} + {1'b0, j};
        pp_ext = '0;
        for (int s = 0; s < 2*CHUNKS - 1; s++) begin
            if (ij_sum == (CW+1)'(s)) pp_ext = PW'(pp) << (3*s);
        end
        acc_nxt = acc + pp_ext;
    end

    assign accept      = (state == IDLE) && bus.in_valid;
    assign last_step   = (state == CALC) && (i == LAST) && (j == LAST);
    assign release_out = (state == DONE) && bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = CALC;
            CALC:    if (last_step)   state_nxt = DONE;
            DONE:    if (release_out) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            CALC: bus.busy     = 1'b1;
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    assign bus.out_p = out_p_reg;

    // Datapath: operand capture, step counters, accumulator, result register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            out_p_reg <= '0;
            i         <= '0;
            j         <= '0;
        end else begin
            if (accept) begin
                a_reg <= bus.in_a;
                b_reg <= bus.in_b;
                acc   <= '0;
                i     <= '0;
                j     <= '0;
            end else if (state == CALC) begin
                acc <= acc_nxt;
                if (j == LAST) begin
                    j <= '0;
                    if (i == LAST) begin
                        i         <= '0;
                        out_p_reg <= acc_nxt;
                    end else begin
                        i <= i + 1'b1;
                    end
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end
endmodule
